// File: rtl/instr_seq_pkg.sv
// ============================================================================
// instr_seq_pkg
// Shared definitions for the instruction sequencer slice.
//   - seq_state_t      : FSM state encoding (IDLE / PRST / ISSUE)
//   - NOP_WORD_DEFAULT : word driven on iin when nothing is being issued
//   - HALT_OPCODE and its field position [15:13], plus a helper to test it
// Optional feature macro used by the files that import this package:
//   INSTR_SEQ_HALT_DETECT_EN
// ============================================================================
package instr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRST  = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_t;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

    localparam int          HALT_MSB    = 15;
    localparam int          HALT_LSB    = 13;
    localparam logic [2:0]  HALT_OPCODE = 3'b111;

    // True when the opcode field of an instruction word is the HALT opcode.
    function automatic logic is_halt(input logic [15:0] word);
        return word[HALT_MSB:HALT_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instr_seq_if.sv
// ============================================================================
// instr_seq_if
// Bundles the program-load controls and the processor-facing instruction
// stream of the sequencer.
//   wr_en, wr_data, start : host -> sequencer (program load and run request)
//   iin, proc_resetn      : sequencer -> processor
//   pc, busy, done, count : sequencer status
//   halted                : only with INSTR_SEQ_HALT_DETECT_EN
// Modports:
//   master : the sequencer (produces the instruction stream)
//   slave  : the host/processor side that loads programs and consumes iin
// ============================================================================
interface instr_seq_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [15:0]   wr_data;
    logic          start;
    logic [15:0]   iin;
    logic          proc_resetn;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
`ifdef INSTR_SEQ_HALT_DETECT_EN
    logic          halted;

    modport master (
        input  wr_en, wr_data, start,
        output iin, proc_resetn, pc, busy, done, count, halted
    );

    modport slave (
        output wr_en, wr_data, start,
        input  iin, proc_resetn, pc, busy, done, count, halted
    );
`else
    modport master (
        input  wr_en, wr_data, start,
        output iin, proc_resetn, pc, busy, done, count
    );

    modport slave (
        output wr_en, wr_data, start,
        input  iin, proc_resetn, pc, busy, done, count
    );
`endif

endinterface

// File: rtl/instr_seq_mem.sv
// ============================================================================
// instr_seq_mem
// DEPTH x 16 program buffer: one synchronous write port, one combinational
// read port. Contents are not reset; only words below the loaded count are
// ever read by the sequencer.
// Ports:
//   clock  : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational)
// ============================================================================
module instr_seq_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Plain register-file write; no reset because stale words are never read.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer
// Instruction source for the 16-bit processor. A program is appended word by
// word while idle; on start the processor is held in reset for RST_CYCLES
// clocks, then each loaded word is presented on iin for HOLD_CYCLES clocks.
// Ports:
//   clock   : system clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : instr_seq_if.master (wr_en, wr_data, start in;
//             iin, proc_resetn, pc, busy, done, count [, halted] out)
// Optional feature macro: INSTR_SEQ_HALT_DETECT_EN
//   When defined, an issued word with opcode [15:13] == 3'b111 ends the run
//   after its hold period and sets the halted output.
// ============================================================================
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter int          HOLD_CYCLES = 4,
    parameter int          RST_CYCLES  = 4,
    parameter logic [15:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    instr_seq_if.master bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int RCW = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES)  : 1;
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]    CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  PC_ONE    = AW'(1);
    localparam logic [RCW-1:0] RST_ONE   = RCW'(1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    seq_state_t     state;
    logic [RCW-1:0] rst_ctr;
    logic [HCW-1:0] hold_ctr;
    logic [AW-1:0]  pc_q;
    logic [AW:0]    count_q;
    logic [15:0]    iin_q;
    logic           proc_resetn_q;
    logic           busy_q;
    logic           done_q;

    logic           mem_we;
    logic [AW-1:0]  mem_raddr;
    logic [15:0]    mem_rdata;
    logic           last_word;
    logic           hold_end;
    logic           halt_exit;

    // Writes are only honoured while idle and while there is room; once the
    // buffer is full further words are dropped and count saturates.
    assign mem_we = (state == ST_IDLE) && bus.wr_en && (count_q != CNT_FULL);

    // The read port always looks one word ahead of iin: word 0 while waiting
    // out the processor reset, pc+1 while issuing, so the next word is ready
    // on the edge where pc advances.
    assign mem_raddr = (state == ST_ISSUE) ? (pc_q + PC_ONE) : '0;

    assign last_word = (({1'b0, pc_q} + CNT_ONE) == count_q);
    assign hold_end  = (hold_ctr == HOLD_LAST);

`ifdef INSTR_SEQ_HALT_DETECT_EN
    logic halted_q;

    assign halt_exit = is_halt(iin_q);
`else
    assign halt_exit = 1'b0;
`endif

    instr_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (count_q[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Sequencer FSM. All outputs are registered and updated on the same edge
    // as the state, so iin and pc always change together and the processor
    // never sees a word that does not match pc. done defaults low every
    // cycle so it can only ever be a single-cycle pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            rst_ctr       <= '0;
            hold_ctr      <= '0;
            pc_q          <= '0;
            count_q       <= '0;
            iin_q         <= NOP_WORD;
            proc_resetn_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef INSTR_SEQ_HALT_DETECT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    iin_q         <= NOP_WORD;
                    proc_resetn_q <= 1'b1;
                    if (mem_we) begin
                        count_q <= count_q + CNT_ONE;
                    end
                    if (bus.start && (count_q != '0)) begin
                        state         <= ST_PRST;
                        rst_ctr       <= '0;
                        proc_resetn_q <= 1'b0;
                        busy_q        <= 1'b1;
`ifdef INSTR_SEQ_HALT_DETECT_EN
                        halted_q      <= 1'b0;
`endif
                    end
                end

                ST_PRST: begin
                    if (rst_ctr == RST_LAST) begin
                        state         <= ST_ISSUE;
                        pc_q          <= '0;
                        hold_ctr      <= '0;
                        iin_q         <= mem_rdata;
                        proc_resetn_q <= 1'b1;
                    end else begin
                        rst_ctr <= rst_ctr + RST_ONE;
                    end
                end

                ST_ISSUE: begin
                    if (hold_end) begin
                        if (last_word || halt_exit) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            iin_q  <= NOP_WORD;
`ifdef INSTR_SEQ_HALT_DETECT_EN
                            halted_q <= halt_exit;
`endif
                        end else begin
                            pc_q     <= pc_q + PC_ONE;
                            hold_ctr <= '0;
                            iin_q    <= mem_rdata;
                        end
                    end else begin
                        hold_ctr <= hold_ctr + HOLD_ONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.iin         = iin_q;
    assign bus.proc_resetn = proc_resetn_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.count       = count_q;
`ifdef INSTR_SEQ_HALT_DETECT_EN
    assign bus.halted      = halted_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// tb_instr_sequencer
// Self-checking bench for instr_sequencer (DEPTH=16, HOLD_CYCLES=4,
// RST_CYCLES=4). Idle-time loading is driven from a vector table; runs are
// checked cycle by cycle against an expected trace built from the loaded
// program. Also exercises INSTR_SEQ_HALT_DETECT_EN when that macro is set.
// ============================================================================
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int HOLD  = 4;
    localparam int RSTC  = 4;
    localparam logic [15:0] NOP = 16'h0000;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    instr_seq_if #(.DEPTH(DEPTH)) bus ();

    instr_sequencer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .RST_CYCLES  (RSTC),
        .NOP_WORD    (NOP)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    typedef struct {
        logic        wr_en;
        logic [15:0] wr_data;
        logic        start;
        int          expCount;
        logic        expBusy;
    } vec_t;

    typedef struct {
        logic [15:0] iin;
        logic        prstn;
        logic        busy;
        logic        done;
        int          pc;
        logic        halted;
    } cyc_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] prog[$];

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [15:0] wd, input logic st);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.start   = st;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_iin"}, 32'(bus.iin), 32'(NOP));
        checkOutput({tag, "_prstn"}, 32'(bus.proc_resetn), 0);
        checkOutput({tag, "_pc"}, 32'(bus.pc), 0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
        checkOutput({tag, "_done"}, 32'(bus.done), 0);
        checkOutput({tag, "_count"}, 32'(bus.count), 0);
`ifdef INSTR_SEQ_HALT_DETECT_EN
        checkOutput({tag, "_halted"}, 32'(bus.halted), 0);
`endif
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        prog.delete();
    endtask

    // Append one word while idle; the model drops words beyond DEPTH.
    task automatic loadWord(input logic [15:0] w);
        applyStimulus(1'b1, w, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        if (prog.size() < DEPTH) prog.push_back(w);
        checkOutput("load_count", 32'(bus.count), 32'(prog.size()));
    endtask

    // Start a run and follow it cycle by cycle. The expected trace comes
    // straight from the rules: RSTC cycles of processor reset, each issued
    // word held for HOLD cycles, then a one-cycle done pulse. junk drives
    // writes and starts during the run, which must be ignored. abortAt >= 0
    // asserts reset in the middle of that cycle and checks the reset values.
    task automatic runProgram(input bit junk, input bit writeWithStart,
                              input logic [15:0] ww, input int abortAt);
        logic [15:0] issued[$];
        cyc_t        trace[$];
        cyc_t        c;
        bit          haltHit;
        int          busyLen;

        if (writeWithStart && prog.size() < DEPTH) prog.push_back(ww);
        haltHit = 0;
        foreach (prog[i]) begin
            issued.push_back(prog[i]);
`ifdef INSTR_SEQ_HALT_DETECT_EN
            if (prog[i][15:13] == 3'b111) begin
                haltHit = 1;
                break;
            end
`endif
        end

        for (int i = 0; i < RSTC; i++) begin
            c = '{iin: NOP, prstn: 1'b0, busy: 1'b1, done: 1'b0, pc: -1, halted: 1'b0};
            trace.push_back(c);
        end
        foreach (issued[w]) begin
            for (int h = 0; h < HOLD; h++) begin
                c = '{iin: issued[w], prstn: 1'b1, busy: 1'b1, done: 1'b0, pc: w, halted: 1'b0};
                trace.push_back(c);
            end
        end
        c = '{iin: NOP, prstn: 1'b1, busy: 1'b0, done: 1'b1, pc: -1, halted: haltHit};
        trace.push_back(c);
        c.done = 1'b0;
        trace.push_back(c);
        busyLen = RSTC + issued.size() * HOLD;

        applyStimulus(writeWithStart, ww, 1'b1);
        foreach (trace[k]) begin
            tick();
            checkOutput($sformatf("run%0d_iin", k), 32'(bus.iin), 32'(trace[k].iin));
            checkOutput($sformatf("run%0d_prstn", k), 32'(bus.proc_resetn), 32'(trace[k].prstn));
            checkOutput($sformatf("run%0d_busy", k), 32'(bus.busy), 32'(trace[k].busy));
            checkOutput($sformatf("run%0d_done", k), 32'(bus.done), 32'(trace[k].done));
            if (trace[k].pc >= 0)
                checkOutput($sformatf("run%0d_pc", k), 32'(bus.pc), 32'(trace[k].pc));
`ifdef INSTR_SEQ_HALT_DETECT_EN
            checkOutput($sformatf("run%0d_halted", k), 32'(bus.halted), 32'(trace[k].halted));
`endif
            if (k == abortAt) begin
                applyStimulus(1'b0, 16'h0000, 1'b0);
                #2;
                resetn = 1'b0;
                #1;
                checkResetValues("midrun");
                tick();
                resetn = 1'b1;
                tick();
                checkOutput("midrun_release_prstn", 32'(bus.proc_resetn), 1);
                prog.delete();
                return;
            end
            if (junk && k < busyLen)
                applyStimulus(1'($urandom_range(0, 1)), 16'hFFFF, 1'($urandom_range(0, 1)));
            else
                applyStimulus(1'b0, 16'h0000, 1'b0);
        end
        checkOutput("run_count", 32'(bus.count), 32'(prog.size()));
    endtask

    // Guard against a stuck simulation.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence.
    initial begin
        vec_t vecs[$];
        vec_t v;

        applyStimulus(1'b0, 16'h0000, 1'b0);
        resetn = 1'b0;
        tick();
        checkResetValues("reset");
        resetn = 1'b1;
        tick();
        checkOutput("release_prstn", 32'(bus.proc_resetn), 1);
        checkOutput("release_busy", 32'(bus.busy), 0);

        $display("[TB] idle vector table");
        v = '{wr_en: 1'b0, wr_data: 16'h0000, start: 1'b1, expCount: 0, expBusy: 1'b0}; vecs.push_back(v);
        v = '{wr_en: 1'b1, wr_data: 16'hA01C, start: 1'b1, expCount: 1, expBusy: 1'b0}; vecs.push_back(v);
        v = '{wr_en: 1'b1, wr_data: 16'hA40A, start: 1'b0, expCount: 2, expBusy: 1'b0}; vecs.push_back(v);
        v = '{wr_en: 1'b1, wr_data: 16'h2080, start: 1'b0, expCount: 3, expBusy: 1'b0}; vecs.push_back(v);
        v = '{wr_en: 1'b1, wr_data: 16'h8000, start: 1'b0, expCount: 4, expBusy: 1'b0}; vecs.push_back(v);
        v = '{wr_en: 1'b0, wr_data: 16'h0000, start: 1'b0, expCount: 4, expBusy: 1'b0}; vecs.push_back(v);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr_en, vecs[i].wr_data, vecs[i].start);
            tick();
            applyStimulus(1'b0, 16'h0000, 1'b0);
            if (vecs[i].wr_en) prog.push_back(vecs[i].wr_data);
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
            tick();
            checkOutput($sformatf("vec%0d_busy2", i), 32'(bus.busy), 32'(vecs[i].expBusy));
        end

        $display("[TB] load and run");
        runProgram(1'b0, 1'b0, 16'h0000, -1);
        $display("[TB] rerun with ignored writes and starts");
        runProgram(1'b1, 1'b0, 16'h0000, -1);
        $display("[TB] write and start in the same cycle");
        runProgram(1'b0, 1'b1, 16'h1234, -1);

        $display("[TB] reset during second instruction");
        runProgram(1'b0, 1'b0, 16'h0000, RSTC + HOLD + 1);
        loadWord(16'hA01C);
        loadWord(16'hA40A);
        loadWord(16'h2080);
        loadWord(16'h8000);
        runProgram(1'b0, 1'b0, 16'h0000, -1);

        $display("[TB] overfill buffer");
        doReset();
        for (int i = 0; i < DEPTH + 1; i++) loadWord(16'h1000 + 16'(i));
        checkOutput("full_count", 32'(bus.count), 32'(DEPTH));
        runProgram(1'b0, 1'b0, 16'h0000, -1);

        $display("[TB] random programs");
        for (int r = 0; r < 6; r++) begin
            int n;
            doReset();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) loadWord(16'($urandom));
            runProgram(1'($urandom_range(0, 1)), 1'b0, 16'h0000, -1);
            runProgram(1'b1, 1'b0, 16'h0000, -1);
        end

`ifdef INSTR_SEQ_HALT_DETECT_EN
        $display("[TB] halt detection");
        doReset();
        loadWord(16'hA01C);
        loadWord(16'hE000);
        loadWord(16'h2080);
        runProgram(1'b0, 1'b0, 16'h0000, -1);
        checkOutput("halt_flag", 32'(bus.halted), 1);
        runProgram(1'b0, 1'b0, 16'h0000, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
